// File: rtl/nmea_sentence_tx.sv
// nmea_sentence_tx
// Frames a sentence body streamed in from control logic as
//   '$' body '*' HH CR LF
// and hands it to the GPS UART one byte at a time via txByte/txStart.
// Optional feature macro: NMEA_TX_CHECKSUM_EN. When it is defined, the '*'
// and the two hex checksum digits are sent. When it is undefined, the body is
// followed directly by CR LF and no checksum register exists.
// Every byte takes an ISSUE cycle (txByte/txStart loaded) and a guard cycle in
// which txBusy is ignored. The following ISSUE only fires once txBusy is low,
// which also serves as the wait phase of the byte before it.
module nmea_sentence_tx #(
  parameter int MAX_PAYLOAD = 76
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic [7:0] payloadByte,
  input  logic       payloadValid,
  input  logic       payloadLast,
  output logic       payloadReady,
  output logic [7:0] txByte,
  output logic       txStart,
  input  logic       txBusy,
  output logic       busy,
  output logic       sentDone,
  output logic       overflow
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DOLLAR,
    ST_PAYLOAD,
    ST_STAR,
    ST_HEX_HI,
    ST_HEX_LO,
    ST_CR,
    ST_LF,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // PH_GUARD holds the successor state in next_q. PH_FINISH exists only in
  // DONE: it is the cycle after the UART has gone idle behind the LF.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_GUARD,
    PH_FINISH
  } phase_t;

  state_t     state_q, state_d;
  state_t     next_q, next_d;
  phase_t     phase_q, phase_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_start_q, tx_start_d;
  logic       sent_done_q, sent_done_d;
  logic       overflow_q, overflow_d;
  logic [6:0] count_q, count_d;
  logic [6:0] count_inc;
  logic       ready;
  logic       emit;
  logic [7:0] emit_byte;
  state_t     emit_next;

`ifdef NMEA_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction
`endif

  // Next-state, byte selection, checksum/count update and output pulses
  always_comb begin
    state_d     = state_q;
    next_d      = next_q;
    phase_d     = phase_q;
    tx_byte_d   = tx_byte_q;
    tx_start_d  = 1'b0;
    sent_done_d = 1'b0;
    overflow_d  = 1'b0;
    count_d     = count_q;
`ifdef NMEA_TX_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    count_inc   = count_q + 7'd1;
    ready       = 1'b0;
    emit        = 1'b0;
    emit_byte   = '0;
    emit_next   = ST_IDLE;

    case (phase_q)
      PH_GUARD: begin
        phase_d = PH_ISSUE;
        state_d = next_q;
      end
      PH_FINISH: begin
        sent_done_d = 1'b1;
        state_d     = ST_IDLE;
        phase_d     = PH_ISSUE;
      end
      default: begin
        case (state_q)
          // The '$' is issued straight from IDLE so it leaves one cycle
          // after the first body byte is seen; DOLLAR only spans its guard.
          ST_IDLE: begin
            if (payloadValid && !txBusy) begin
              count_d   = '0;
`ifdef NMEA_TX_CHECKSUM_EN
              csum_d    = '0;
`endif
              emit      = 1'b1;
              emit_byte = 8'h24;
              emit_next = ST_PAYLOAD;
              state_d   = ST_DOLLAR;
            end
          end
          ST_PAYLOAD: begin
            if (payloadValid && !txBusy) begin
              ready     = 1'b1;
              emit      = 1'b1;
              emit_byte = payloadByte;
              count_d   = count_inc;
`ifdef NMEA_TX_CHECKSUM_EN
              csum_d    = csum_q ^ payloadByte;
`endif
              if (payloadLast) begin
`ifdef NMEA_TX_CHECKSUM_EN
                emit_next = ST_STAR;
`else
                emit_next = ST_CR;
`endif
              end else if (count_inc == MAX_CNT) begin
                overflow_d = 1'b1;
                emit_next  = ST_DRAIN;
              end else begin
                emit_next = ST_PAYLOAD;
              end
            end
          end
`ifdef NMEA_TX_CHECKSUM_EN
          ST_STAR: begin
            emit      = !txBusy;
            emit_byte = 8'h2A;
            emit_next = ST_HEX_HI;
          end
          ST_HEX_HI: begin
            emit      = !txBusy;
            emit_byte = hex_ascii(csum_q[7:4]);
            emit_next = ST_HEX_LO;
          end
          ST_HEX_LO: begin
            emit      = !txBusy;
            emit_byte = hex_ascii(csum_q[3:0]);
            emit_next = ST_CR;
          end
`endif
          ST_CR: begin
            emit      = !txBusy;
            emit_byte = 8'h0D;
            emit_next = ST_LF;
          end
          ST_LF: begin
            emit      = !txBusy;
            emit_byte = 8'h0A;
            emit_next = ST_DONE;
          end
          ST_DRAIN: begin
            ready = 1'b1;
            if (payloadValid && payloadLast) begin
              state_d = ST_CR;
            end
          end
          ST_DONE: begin
            if (!txBusy) begin
              phase_d = PH_FINISH;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase

        if (emit) begin
          tx_byte_d  = emit_byte;
          tx_start_d = 1'b1;
          phase_d    = PH_GUARD;
          next_d     = emit_next;
        end
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      next_q      <= ST_IDLE;
      phase_q     <= PH_ISSUE;
      tx_byte_q   <= '0;
      tx_start_q  <= 1'b0;
      sent_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
`ifdef NMEA_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      phase_q     <= phase_d;
      tx_byte_q   <= tx_byte_d;
      tx_start_q  <= tx_start_d;
      sent_done_q <= sent_done_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
`ifdef NMEA_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign payloadReady = ready;
  assign txByte       = tx_byte_q;
  assign txStart      = tx_start_q;
  assign sentDone     = sent_done_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
